bcd_scan_display: RTL and testbench

//  Downstream consumer of the cascaded BCD up/down counter digits (CNT100 chain).

---
 rtl/bcd_scan_display_if.sv | 23 ++
 rtl/bcd_scan_display.sv | 107 ++++++++++
 tb/tb_bcd_scan_display.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/bcd_scan_display_if.sv
// Display-side bundle for bcd_scan_display: BCD digits and strobes in, segment/select drive out.
// master = digit source / observer, slave = the scanning display driver.
interface bcd_scan_display_if #(
  parameter int NDIG = 2,
  parameter int IW   = (NDIG > 1) ? $clog2(NDIG) : 1
);
  logic [4*NDIG-1:0] DIGITS;
  logic              LATCH;
  logic              BLANK;
  logic [6:0]        SEG;
  logic [NDIG-1:0]   AN;
  logic [IW-1:0]     SCAN_IDX;

  modport master (
    output DIGITS, LATCH, BLANK,
    input  SEG, AN, SCAN_IDX
  );

  modport slave (
    input  DIGITS, LATCH, BLANK,
    output SEG, AN, SCAN_IDX
  );
endinterface

// File: rtl/bcd_scan_display.sv
// Snapshots NDIG BCD digits and time-multiplexes them onto one 7-segment bus with a dark guard cycle per slot.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zero digits above digit 0.
module bcd_scan_display #(
  parameter int NDIG     = 2,
  parameter int PRESCALE = 1000
) (
  input  logic              CLK,
  input  logic              RESET_B,
  bcd_scan_display_if.slave bus
);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB_EN = 1'b1;
`else
  localparam bit LZB_EN = 1'b0;
`endif

  typedef enum logic {SLOT_GUARD = 1'b0, SLOT_LIT = 1'b1} slot_e;

  logic [PW-1:0]     pre_r;
  slot_e             phase_r;
  logic [IW-1:0]     idx_r;
  logic [4*NDIG-1:0] shadow_r;
  logic [6:0]        seg_r;
  logic [NDIG-1:0]   an_r;

  logic              tick_s;
  logic [3:0]        cur_digit_s;
  logic [NDIG-1:0]   an_lit_s;
  logic              lz_blank_s;
  logic              zero_run_s;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  assign tick_s       = (pre_r == PRE_LAST);
  assign bus.SEG      = seg_r;
  assign bus.AN       = an_r;
  assign bus.SCAN_IDX = idx_r;

  // Select the current shadow digit, its select pattern, and whether it is a leading zero.
  always_comb begin
    cur_digit_s = 4'd0;
    an_lit_s    = {NDIG{1'b1}};
    lz_blank_s  = 1'b0;
    zero_run_s  = 1'b1;
    // Walk from the most significant digit so zero_run_s means "this digit and all above are 0".
    for (int k = NDIG - 1; k >= 0; k--) begin
      zero_run_s = zero_run_s && (shadow_r[4*k +: 4] == 4'd0);
      if (idx_r == IW'(k)) begin
        cur_digit_s = shadow_r[4*k +: 4];
        an_lit_s[k] = 1'b0;
        lz_blank_s  = LZB_EN && zero_run_s && (k != 0);
      end else begin
        an_lit_s[k] = 1'b1;
      end
    end
  end

  // Prescaler, shadow capture, scan index and slot phase; all outputs registered here.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      pre_r    <= {PW{1'b0}};
      phase_r  <= SLOT_GUARD;
      idx_r    <= {IW{1'b0}};
      shadow_r <= {(4*NDIG){1'b0}};
      seg_r    <= 7'h00;
      an_r     <= {NDIG{1'b1}};
    end else begin
      pre_r <= tick_s ? {PW{1'b0}} : pre_r + PW'(1);
      if (bus.LATCH) begin
        shadow_r <= bus.DIGITS;
      end
      if (tick_s) begin
        idx_r   <= (idx_r == IDX_LAST) ? {IW{1'b0}} : idx_r + IW'(1);
        an_r    <= {NDIG{1'b1}};
        phase_r <= SLOT_GUARD;
      end else if (phase_r == SLOT_GUARD) begin
        seg_r   <= lz_blank_s ? 7'h00 : bcd_to_seg(cur_digit_s);
        an_r    <= lz_blank_s ? {NDIG{1'b1}} : an_lit_s;
        phase_r <= SLOT_LIT;
      end
      // BLANK wins over the guard load; the scan keeps running underneath.
      if (bus.BLANK) begin
        an_r <= {NDIG{1'b1}};
      end
    end
  end
endmodule

// File: tb/tb_bcd_scan_display.sv
// Bench for bcd_scan_display (NDIG=2, PRESCALE=4): directed literal checks plus random stimulus
// compared every cycle against a slot-arithmetic model. Honours LEADING_ZERO_BLANK_EN.
module tb_bcd_scan_display;
  localparam int NDIG = 2;
  localparam int P    = 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif
  localparam logic [6:0] SEG_TAB [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                            7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  logic CLK = 1'b0;
  logic RESET_B = 1'b1;
  int   total = 0;
  int   bad = 0;

  bcd_scan_display_if #(.NDIG(NDIG)) bus ();

  bcd_scan_display #(.NDIG(NDIG), .PRESCALE(P)) dut (
    .CLK     (CLK),
    .RESET_B (RESET_B),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: edges since reset release drive all timing by plain division.
  int         n;
  int         m_pre;
  int         m_slot_idx;
  int         m_idx;
  logic [7:0] m_shadow;
  logic [6:0] m_seg;
  logic [1:0] m_an;
  logic [3:0] m_d;
  bit         m_lzb;

  always @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      n        = 0;
      m_shadow = 8'h00;
      m_seg    = 7'h00;
      m_an     = 2'b11;
      m_idx    = 0;
    end else begin
      m_pre      = n % P;
      m_slot_idx = (n / P) % NDIG;
      if (m_pre == P - 1) begin
        m_an = 2'b11;
      end else if (m_pre == 0) begin
        m_d   = 4'((m_shadow >> (4 * m_slot_idx)) & 8'h0F);
        m_lzb = LZB && (m_slot_idx > 0) && ((m_shadow >> (4 * m_slot_idx)) == 8'h00);
        m_seg = m_lzb ? 7'h00 : SEG_TAB[m_d];
        m_an  = m_lzb ? 2'b11 : ~(2'b01 << m_slot_idx);
      end
      if (bus.BLANK) m_an = 2'b11;
      if (bus.LATCH) m_shadow = bus.DIGITS;
      m_idx = ((n + 1) / P) % NDIG;
      n++;
    end
    #1;
    chk("model SEG", 32'(bus.SEG), 32'(m_seg));
    chk("model AN", 32'(bus.AN), 32'(m_an));
    chk("model SCAN_IDX", 32'(bus.SCAN_IDX), 32'(m_idx));
  end

  initial begin
    bus.DIGITS = 8'h00;
    bus.LATCH  = 1'b0;
    bus.BLANK  = 1'b0;
    #2 RESET_B = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset AN", 32'(bus.AN), 32'h3);
    chk("reset SEG", 32'(bus.SEG), 32'h00);
    chk("reset IDX", 32'(bus.SCAN_IDX), 32'h0);
    bus.DIGITS = 8'h47;
    bus.LATCH  = 1'b1;
    RESET_B    = 1'b1;
    @(negedge CLK);  // after edge 0
    bus.LATCH = 1'b0;
    chk("first digit0 AN", 32'(bus.AN), 32'h2);
    chk("first digit0 SEG", 32'(bus.SEG), 32'h3F);
    repeat (8) @(negedge CLK);  // edge 8
    chk("scan d0 SEG 7", 32'(bus.SEG), 32'h07);
    chk("scan d0 AN", 32'(bus.AN), 32'h2);
    repeat (3) @(negedge CLK);  // edge 11
    chk("guard AN", 32'(bus.AN), 32'h3);
    chk("guard IDX", 32'(bus.SCAN_IDX), 32'h1);
    @(negedge CLK);  // edge 12
    chk("scan d1 SEG 4", 32'(bus.SEG), 32'h66);
    chk("scan d1 AN", 32'(bus.AN), 32'h1);
    bus.DIGITS = 8'h9A;
    repeat (4) @(negedge CLK);  // edge 16
    chk("no latch hold", 32'(bus.SEG), 32'h07);
    bus.LATCH = 1'b1;
    @(negedge CLK);
    bus.LATCH = 1'b0;
    repeat (3) @(negedge CLK);  // edge 20
    chk("d1 nine", 32'(bus.SEG), 32'h6F);
    repeat (4) @(negedge CLK);  // edge 24
    chk("d0 invalid dash", 32'(bus.SEG), 32'h40);
    chk("d0 invalid AN", 32'(bus.AN), 32'h2);
    bus.DIGITS = 8'h05;
    bus.LATCH  = 1'b1;
    @(negedge CLK);
    bus.LATCH = 1'b0;
    repeat (3) @(negedge CLK);  // edge 28
`ifdef LEADING_ZERO_BLANK_EN
    chk("lzb 05 d1 AN", 32'(bus.AN), 32'h3);
    chk("lzb 05 d1 SEG", 32'(bus.SEG), 32'h00);
`else
    chk("nolzb 05 d1 AN", 32'(bus.AN), 32'h1);
    chk("nolzb 05 d1 SEG", 32'(bus.SEG), 32'h3F);
`endif
    repeat (4) @(negedge CLK);  // edge 32
    chk("05 d0 SEG", 32'(bus.SEG), 32'h6D);
    bus.DIGITS = 8'h00;
    bus.LATCH  = 1'b1;
    @(negedge CLK);
    bus.LATCH = 1'b0;
    repeat (3) @(negedge CLK);  // edge 36
`ifdef LEADING_ZERO_BLANK_EN
    chk("lzb 00 d1 AN", 32'(bus.AN), 32'h3);
`else
    chk("nolzb 00 d1 SEG", 32'(bus.SEG), 32'h3F);
`endif
    repeat (4) @(negedge CLK);  // edge 40
    chk("00 d0 SEG", 32'(bus.SEG), 32'h3F);
    chk("00 d0 AN", 32'(bus.AN), 32'h2);
    repeat (2) @(negedge CLK);  // edge 42
    bus.DIGITS = 8'h12;
    bus.LATCH  = 1'b1;
    @(negedge CLK);  // edge 43 is a tick
    bus.LATCH = 1'b0;
    @(negedge CLK);  // edge 44
    chk("latch on tick SEG", 32'(bus.SEG), 32'h06);
    chk("latch on tick AN", 32'(bus.AN), 32'h1);
    bus.BLANK = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);  // edges 45..49
      chk("blank AN", 32'(bus.AN), 32'h3);
      if (i == 0) chk("blank IDX a", 32'(bus.SCAN_IDX), 32'h1);
      if (i == 3) chk("blank IDX b", 32'(bus.SCAN_IDX), 32'h0);
    end
    bus.BLANK = 1'b0;
    repeat (3) @(negedge CLK);  // edge 52
    chk("relight SEG", 32'(bus.SEG), 32'h06);
    chk("relight AN", 32'(bus.AN), 32'h1);
    @(negedge CLK);
    #2 RESET_B = 1'b0;
    #1;
    chk("midslot reset AN", 32'(bus.AN), 32'h3);
    chk("midslot reset SEG", 32'(bus.SEG), 32'h00);
    chk("midslot reset IDX", 32'(bus.SCAN_IDX), 32'h0);
    @(negedge CLK);
    RESET_B = 1'b1;
    @(negedge CLK);
    chk("post reset d0 SEG", 32'(bus.SEG), 32'h3F);
    chk("post reset d0 AN", 32'(bus.AN), 32'h2);

    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      bus.DIGITS = 8'($urandom);
      bus.LATCH  = ($urandom_range(0, 3) == 0);
      bus.BLANK  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 RESET_B = 1'b0;
        @(negedge CLK);
        RESET_B = 1'b1;
      end
    end
    repeat (3) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
